// File: rtl/multi_counter_fsm.sv
// multi_counter_fsm: NUM_CH independent start/done counter FSMs.
// Define MULTI_CNT_PRESCALE_EN to add the shared prescale tick divider.
module multi_counter_fsm #(
    parameter int NUM_CH     = 4,
    parameter int WIDTH      = 32,
    parameter int PRESCALE_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       abort,
    input  logic [NUM_CH-1:0]       mode,
    input  logic [NUM_CH*WIDTH-1:0] N,
`ifdef MULTI_CNT_PRESCALE_EN
    input  logic [PRESCALE_W-1:0]   prescale,
`endif
    output logic [NUM_CH-1:0]       done,
    output logic [NUM_CH-1:0]       wrap,
    output logic                    any_done,
    output logic [NUM_CH*WIDTH-1:0] count,
    output logic [NUM_CH*2-1:0]     state_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    if (NUM_CH < 1 || NUM_CH > 16 || WIDTH < 1 || PRESCALE_W < 1) begin : g_bad_cfg
        $error("multi_counter_fsm: illegal parameter set");
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_t           st_q;
        state_t           st_d;
        logic [WIDTH-1:0] cnt_q;
        logic [WIDTH-1:0] cnt_d;
        logic [WIDTH-1:0] tgt_q;
        logic             md_q;
        logic             adv;
        logic             hit;
        logic             go;
        logic             done_c;
        logic             wrap_c;

`ifdef MULTI_CNT_PRESCALE_EN
        logic [PRESCALE_W-1:0] div_q;
        logic [PRESCALE_W-1:0] div_d;

        assign adv   = (st_q == S_RUN) && (div_q == prescale);
        assign div_d = (st_q == S_RUN && !abort[c] && !adv) ?
                       div_q + PRESCALE_W'(1) : '0;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) div_q <= '0;
            else     div_q <= div_d;
        end
`else
        assign adv = (st_q == S_RUN);
`endif

        assign hit = adv && (cnt_q == tgt_q);
        assign go  = (st_q == S_IDLE) && start[c] && !abort[c];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                st_q  <= S_IDLE;
                cnt_q <= '0;
                tgt_q <= '0;
                md_q  <= 1'b0;
            end else begin
                st_q  <= st_d;
                cnt_q <= cnt_d;
                if (go) begin
                    tgt_q <= N[c*WIDTH +: WIDTH];
                    md_q  <= mode[c];
                end
            end
        end

        // Abort and the illegal encoding both fall through to IDLE, count 0.
        always_comb begin
            st_d  = S_IDLE;
            cnt_d = '0;
            if (!abort[c]) begin
                unique case (st_q)
                    S_IDLE: st_d = start[c] ? S_RUN : S_IDLE;
                    S_RUN: begin
                        st_d  = S_RUN;
                        cnt_d = cnt_q;
                        if (hit) begin
                            if (md_q && start[c]) cnt_d = '0;
                            else                  st_d  = S_DONE;
                        end else if (adv) begin
                            cnt_d = cnt_q + WIDTH'(1);
                        end
                    end
                    S_DONE: begin
                        st_d  = start[c] ? S_DONE : S_IDLE;
                        cnt_d = start[c] ? cnt_q : '0;
                    end
                    default: ;
                endcase
            end
        end

        always_comb begin
            done_c = (st_q == S_DONE);
            wrap_c = hit && md_q && start[c] && !abort[c];
        end

        assign done[c]                 = done_c;
        assign wrap[c]                 = wrap_c;
        assign count[c*WIDTH +: WIDTH] = cnt_q;
        assign state_out[c*2 +: 2]     = st_q;
    end

    assign any_done = |done;

endmodule

// File: tb/tb_multi_counter_fsm.sv
// tb_multi_counter_fsm: directed scoreboard bench for multi_counter_fsm.
// Build with MULTI_CNT_PRESCALE_EN defined to cover the prescaler too.
module tb_multi_counter_fsm;

    localparam int NC = 4;
    localparam int W  = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [NC-1:0]   start;
    logic [NC-1:0]   abort;
    logic [NC-1:0]   mode;
    logic [NC*W-1:0] N;
    logic [NC-1:0]   done;
    logic [NC-1:0]   wrap;
    logic            any_done;
    logic [NC*W-1:0] count;
    logic [NC*2-1:0] state_out;
`ifdef MULTI_CNT_PRESCALE_EN
    logic [7:0]      prescale;
`endif

    multi_counter_fsm #(.NUM_CH(NC), .WIDTH(W), .PRESCALE_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .abort(abort),
        .mode(mode),
        .N(N),
`ifdef MULTI_CNT_PRESCALE_EN
        .prescale(prescale),
`endif
        .done(done),
        .wrap(wrap),
        .any_done(any_done),
        .count(count),
        .state_out(state_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        string       tag;
        int          kind;
        int          ch;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] obs(int kind, int ch);
        case (kind)
            0:       return 32'(count[ch*W +: W]);
            1:       return 32'(state_out[ch*2 +: 2]);
            2:       return 32'(done[ch]);
            3:       return 32'(wrap[ch]);
            4:       return 32'(any_done);
            default: return 32'(done);
        endcase
    endfunction

    task automatic check(string tag, logic [31:0] o, logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic expect_at(int due, string tag, int kind, int ch, logic [31:0] val);
        exp_t x;
        x.due  = due;
        x.tag  = tag;
        x.kind = kind;
        x.ch   = ch;
        x.val  = val;
        sb.push_back(x);
    endtask

    task automatic step();
        exp_t keep[$];
        @(negedge clk);
        foreach (sb[i]) begin
            if (sb[i].due == cyc) check(sb[i].tag, obs(sb[i].kind, sb[i].ch), sb[i].val);
            else keep.push_back(sb[i]);
        end
        sb = keep;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(int c);
        while (cyc < c) step();
    endtask

    task automatic set_n(int ch, logic [W-1:0] v);
        N[ch*W +: W] = v;
    endtask

    initial begin
        int t;
        int t3;
        rst   = 1'b1;
        start = '0;
        abort = '0;
        mode  = '0;
        N     = '0;
`ifdef MULTI_CNT_PRESCALE_EN
        prescale = 8'd0;
`endif
        @(posedge clk);
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_state", 32'(state_out), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_wrap", 32'(wrap), 32'd0);
        check("rst_any", 32'(any_done), 32'd0);
        rst = 1'b0;
        step();

        // one-shot ch0, N=5
        t = cyc;
        set_n(0, 8'd5);
        start[0] = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            expect_at(t+1+k, "os_cnt", 0, 0, 32'(k));
            expect_at(t+1+k, "os_run", 1, 0, 32'd1);
        end
        expect_at(t+6, "os_done_lo", 2, 0, 32'd0);
        expect_at(t+7, "os_done", 2, 0, 32'd1);
        expect_at(t+7, "os_cnt_hold", 0, 0, 32'd5);
        expect_at(t+8, "os_done_st", 1, 0, 32'd2);
        expect_at(t+9, "os_done_lvl", 1, 0, 32'd2);
        expect_at(t+10, "os_idle", 1, 0, 32'd0);
        expect_at(t+10, "os_cnt0", 0, 0, 32'd0);
        run_to(t+9);
        start[0] = 1'b0;
        run_to(t+11);

        // periodic ch1, N=3, start dropped mid-period
        t = cyc;
        set_n(1, 8'd3);
        mode[1]  = 1'b1;
        start[1] = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            expect_at(t+i, "per_cnt", 0, 1, 32'((i-1) % 4));
            expect_at(t+i, "per_wrap", 3, 1, (i == 4 || i == 8) ? 32'd1 : 32'd0);
        end
        expect_at(t+13, "per_done", 1, 1, 32'd2);
        expect_at(t+13, "per_cnt3", 0, 1, 32'd3);
        expect_at(t+14, "per_idle", 1, 1, 32'd0);
        expect_at(t+14, "per_cnt0", 0, 1, 32'd0);
        run_to(t+10);
        start[1] = 1'b0;
        mode[1]  = 1'b0;
        run_to(t+15);

        // abort ch2 at count 7 of N=20
        t = cyc;
        set_n(2, 8'd20);
        start[2] = 1'b1;
        expect_at(t+8, "ab_cnt7", 0, 2, 32'd7);
        expect_at(t+9, "ab_idle", 1, 2, 32'd0);
        expect_at(t+9, "ab_cnt0", 0, 2, 32'd0);
        expect_at(t+10, "ab_stay", 1, 2, 32'd0);
        run_to(t+8);
        abort[2] = 1'b1;
        start[2] = 1'b0;
        run_to(t+9);
        abort[2] = 1'b0;
        run_to(t+11);

        // abort on the terminal count of a periodic channel
        t = cyc;
        set_n(3, 8'd2);
        mode[3]  = 1'b1;
        start[3] = 1'b1;
        expect_at(t+3, "abt_cnt2", 0, 3, 32'd2);
        expect_at(t+3, "abt_nowrap", 3, 3, 32'd0);
        expect_at(t+4, "abt_idle", 1, 3, 32'd0);
        expect_at(t+4, "abt_cnt0", 0, 3, 32'd0);
        expect_at(t+5, "abt_stay", 1, 3, 32'd0);
        run_to(t+3);
        abort[3] = 1'b1;
        run_to(t+4);
        abort[3] = 1'b0;
        start[3] = 1'b0;
        mode[3]  = 1'b0;
        run_to(t+6);

        // asynchronous reset mid-RUN
        t = cyc;
        set_n(0, 8'd50);
        start[0] = 1'b1;
        expect_at(t+4, "rr_cnt3", 0, 0, 32'd3);
        run_to(t+5);
        #2;
        rst = 1'b1;
        #1;
        check("rr_count", 32'(count), 32'd0);
        check("rr_state", 32'(state_out), 32'd0);
        check("rr_done", 32'(done), 32'd0);
        check("rr_any", 32'(any_done), 32'd0);
        start[0] = 1'b0;
        step();
        rst = 1'b0;
        expect_at(cyc+1, "rr_after", 1, 0, 32'd0);
        run_to(cyc+2);

        // independent channels, N = 0,1,2,255, staggered starts
        t  = cyc;
        t3 = t + 3;
        mode = '0;
        set_n(0, 8'd0);
        set_n(1, 8'd1);
        set_n(2, 8'd2);
        set_n(3, 8'd255);
        for (int c = 0; c < 3; c++) begin
            expect_at(t+c+c+1, "ind_done_lo", 2, c, 32'd0);
            expect_at(t+c+c+2, "ind_done", 2, c, 32'd1);
            expect_at(t+c+c+2, "ind_state", 1, c, 32'd2);
        end
        expect_at(t+1, "ind_any_lo", 4, 0, 32'd0);
        expect_at(t+2, "ind_any_hi", 4, 0, 32'd1);
        expect_at(t+11, "ind_idle0", 1, 0, 32'd0);
        expect_at(t+11, "ind_idle2", 1, 2, 32'd0);
        expect_at(t+11, "ind_any_off", 4, 0, 32'd0);
        expect_at(t3+100, "big_cnt99", 0, 3, 32'd99);
        expect_at(t3+256, "big_cnt255", 0, 3, 32'd255);
        expect_at(t3+256, "big_run", 1, 3, 32'd1);
        expect_at(t3+256, "big_nowrap", 3, 3, 32'd0);
        expect_at(t3+257, "big_done", 1, 3, 32'd2);
        expect_at(t3+257, "big_cnt_hold", 0, 3, 32'd255);
        expect_at(t3+257, "big_bus", 5, 0, 32'h8);
        expect_at(t3+257, "big_any", 4, 0, 32'd1);
        for (int c = 0; c < NC; c++) begin
            start[c] = 1'b1;
            step();
        end
        set_n(3, 8'd10);
        mode[3] = 1'b1;
        run_to(t+10);
        start[2:0] = '0;
        run_to(t3+258);
        start[3] = 1'b0;
        mode[3]  = 1'b0;
        expect_at(t3+259, "big_idle", 1, 3, 32'd0);
        run_to(t3+260);

`ifdef MULTI_CNT_PRESCALE_EN
        // prescaled one-shot, P=2, N=3
        t = cyc;
        prescale = 8'd2;
        set_n(0, 8'd3);
        start[0] = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            expect_at(t+i, "ps_cnt", 0, 0, 32'((i-1) / 3));
        end
        expect_at(t+12, "ps_run", 1, 0, 32'd1);
        expect_at(t+13, "ps_done", 1, 0, 32'd2);
        run_to(t+14);
        start[0] = 1'b0;
        run_to(t+16);
`endif

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_counter_fsm.md
# multi_counter_fsm

- `NUM_CH` independent start/done counter FSMs sharing one clock and reset.
- Each channel has its own target, which is latched at start.
- Each channel has its own mode: one-shot or periodic, also latched at start.
- Each channel has an abort input and an observable state.
- The block is the parametrised successor of the single-channel counter FSM and sits between the control sequencer and per-lane datapath engines.

## Interface
Parameters:
- `NUM_CH`, default 4: number of channels, range 1–16.
- `WIDTH`, default 32: counter/target width per channel.
- `PRESCALE_W`, default 8: prescaler width; used only with `MULTI_CNT_PRESCALE_EN`.

Ports (channel c occupies slice `[c*W +: W]` of each bus):
- `clk` in 1: the block's single clock; all registers update on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in NUM_CH: per-channel start level.
- `abort` in NUM_CH: per-channel synchronous abort.
- `mode` in NUM_CH: 0 = one-shot, 1 = periodic.
- `N` in NUM_CH*WIDTH: per-channel target.
- `prescale` in PRESCALE_W: shared tick divider; present only with the macro.
- `done` out NUM_CH: per-channel DONE indicator.
- `wrap` out NUM_CH: one-cycle periodic-wrap pulse.
- `any_done` out 1: OR of `done`.
- `count` out NUM_CH*WIDTH: per-channel count.
- `state_out` out NUM_CH*2: per-channel state (IDLE=2'b00, RUN=2'b01, DONE=2'b10).

## Operation
- Per-channel registers: state, count, latched target `tgt`, latched mode `md`.
- Reset values of these registers:
  - state = IDLE, count = 0, tgt = 0, md = 0.
  - Hence `done`, `wrap`, `any_done` = 0 and `state_out` = 0.
- Channels are fully independent; no shared arbitration.
- `abort[c]` has highest priority: from any state, next cycle state = IDLE and count = 0.
- IDLE:
  - count held at 0.
  - `start` = 1 → RUN next cycle, count = 0, `tgt` ← N slice, `md` ← `mode`.
- RUN: count increments by 1 per advance (every cycle without the macro). At an advance with count == `tgt`:
  - `md` = 0 → DONE; count holds `tgt`.
  - `md` = 1 and `start` = 1 → count wraps to 0, state stays RUN, `wrap` asserts for that cycle.
  - `md` = 1 and `start` = 0 → DONE (the current period completes, then the channel stops).
- RUN ignores `start` rising and changes to `N`/`mode`; only the latched `tgt`/`md` are used.
- DONE:
  - `done` = 1; count holds `tgt`.
  - `start` = 0 → IDLE next cycle, count = 0.
  - `start` = 1 → stay in DONE (level handshake).
- Illegal state encoding 2'b11 → IDLE next cycle, count = 0.
- Output definitions:
  - `done` = (state == DONE), combinational from the state register.
  - `wrap` = RUN && `md` && advance && count == `tgt` && `start`, combinational.
  - `count` and `state_out` are direct register outputs.
- Arithmetic and width rules:
  - All comparisons are unsigned, WIDTH bits.
  - count never exceeds `tgt`, so no overflow is possible; `tgt` = 2^WIDTH−1 is legal.
- `tgt` = 0 (one-shot): one RUN cycle, then DONE.

## Timing
- `start` sampled high at edge t:
  - RUN with count = 0 from t+1.
  - count = k at t+1+k.
  - DONE at t+N+2 (no prescale).
- Prescale enabled, value P: each advance takes P+1 cycles; DONE at t+1+(N+1)(P+1).
- DONE → IDLE: one cycle after `start` is sampled low.
- Restart from IDLE: needs `start` high again, so the minimum IDLE dwell is 1 cycle.
- Reset mid-operation: immediate (asynchronous) return to reset values; the first state change is at the first edge after `rst` falls.
- Abort coinciding with a terminal count: abort wins; no `wrap` pulse, no DONE.

## Configuration
- Macro: `MULTI_CNT_PRESCALE_EN`.
- With the macro defined:
  - The `prescale` port exists, with one shared divider counter per channel.
  - The divider is cleared on entry to RUN and on abort.
  - An advance occurs when the divider reaches `prescale`; the divider then wraps to 0.
  - `prescale` is sampled live, not latched.
- Without the macro: the `prescale` port and divider logic are absent, and every RUN cycle is an advance.

## Test plan
- One-shot, ch0: N=5, `start` held high at t → count 0..5 over t+1..t+6, `done[0]` = 1 at t+7 with count = 5; `start` low → IDLE and count = 0 one cycle later.
- Periodic, ch1: N=3, `start` held high → `wrap[1]` pulses every 4 cycles with count 0,1,2,3,0…; `start` dropped mid-period → finishes at count = 3, then DONE.
- Abort and reset:
  - `abort[2]` asserted at count = 7 of N=20 → IDLE, count = 0 next cycle.
  - `rst` asserted mid-RUN → all outputs 0 immediately.
- Independence and latching:
  - All 4 channels started on different cycles with N = 0, 1, 2, 255 → each done at its own t+N+2.
  - `any_done` is the OR of `done`.
  - Changing `N`/`mode` during RUN has no effect.
- Boundary values:
  - N = 0 one-shot → DONE 2 cycles after start.
  - WIDTH=8 with N = 255 → count reaches 255 without wrap, then DONE.
- `MULTI_CNT_PRESCALE_EN` with P=2, N=3 → count steps every 3 cycles and DONE at t+13.
